// File: rtl/sigma_delta_pkg.sv
// Shared sigma-delta definitions: CIC order and the internal accumulator width.
// Also used by the sigma_delta_dac tests.
package sigma_delta_pkg;

    localparam int CIC_ORDER = 2;

    // Growth of an order-N CIC at ratio 2^log2_r is N*log2_r bits; one spare bit keeps the full-scale code R^N representable.
    function automatic int cic_width(input int log2_r);
        return CIC_ORDER * log2_r + 1;
    endfunction

endpackage

// File: rtl/sigma_delta_decimator_cic2.sv
// Second-order CIC core: two integrators at the bit rate, a phase counter and a two-stage comb.
// o_c2 is the raw comb output, valid in the cycle o_result_valid is high.
module cic2_core
    import sigma_delta_pkg::*;
#(
    parameter int LOG2_R = 5,
    localparam int W = cic_width(LOG2_R)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_bit_en,
    input  logic         i_pdm_in,
    output logic [W-1:0] o_c2,
    output logic         o_result_valid
);

    logic [LOG2_R-1:0] r_phase;
    logic [W-1:0]      r_int1;
    logic [W-1:0]      r_int2;
    logic [W-1:0]      r_d1;
    logic [W-1:0]      r_d2;
    logic              r_tick;

    logic              w_tick;
    logic [W-1:0]      w_c1;
    logic [W-1:0]      w_c2;

    assign w_tick = i_bit_en && (r_phase == '1);

    // Comb runs the cycle after the tick, on the int2 value that includes the last bit of the window.
    assign w_c1 = r_int2 - r_d1;
    assign w_c2 = w_c1 - r_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_int1  <= '0;
            r_int2  <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (i_bit_en) begin
                r_int1  <= r_int1 + {{(W-1){1'b0}}, i_pdm_in};
                r_int2  <= r_int2 + r_int1;
                r_phase <= r_phase + 1'b1;
            end
            r_tick <= w_tick;
            if (r_tick) begin
                r_d1 <= r_int2;
                r_d2 <= w_c1;
            end
        end
    end

    assign o_c2           = w_c2;
    assign o_result_valid = r_tick;

endmodule

// File: rtl/sigma_delta_decimator.sv
// Sigma-delta decimator: CIC2 core, priming of the first two results, scaling/saturation,
// single-entry valid/ready output register and a sticky overrun flag.
module sigma_delta_decimator
    import sigma_delta_pkg::*;
#(
    parameter int CODE_WIDTH = 10,
    parameter int LOG2_R     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_en,
    input  logic                  pdm_in,
    output logic [CODE_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int             W        = cic_width(LOG2_R);
    localparam int             SHIFT    = 2 * LOG2_R - CODE_WIDTH;
    localparam logic [W-1:0]   CODE_MAX = W'((1 << CODE_WIDTH) - 1);

    logic [W-1:0]          w_c2;
    logic                  w_result;
    logic [W-1:0]          w_shifted;
    logic [CODE_WIDTH-1:0] w_code;
    logic                  w_primed;
    logic                  w_new;
    logic                  w_xfer;

    logic [1:0]            r_prime;
    logic [CODE_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    cic2_core #(
        .LOG2_R (LOG2_R)
    ) u_core (
        .clk            (clk),
        .rst            (rst),
        .i_bit_en       (bit_en),
        .i_pdm_in       (pdm_in),
        .o_c2           (w_c2),
        .o_result_valid (w_result)
    );

    // Full scale is exactly R^2, one past the largest code, so it must clip.
    assign w_shifted = w_c2 >> SHIFT;
    assign w_code    = (w_shifted > CODE_MAX) ? CODE_MAX[CODE_WIDTH-1:0] : w_shifted[CODE_WIDTH-1:0];

    assign w_primed  = (r_prime == 2'd2);
    assign w_new     = w_result && w_primed;

    // Transfer when sample_valid & sample_ready; data is held while valid and not ready.
    assign w_xfer    = r_valid && sample_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prime   <= 2'd0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_result && !w_primed) begin
                r_prime <= r_prime + 2'd1;
            end

            if (w_new && (!r_valid || w_xfer)) begin
                r_data  <= w_code;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            // A dropped result outranks a clear arriving in the same cycle.
            if (w_new && r_valid && !sample_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign sample_data  = r_data;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: doc/sigma_delta_decimator.md
SIGMA_DELTA_DECIMATOR -- requirements
Module: sigma_delta_decimator

Interface
REQ-001 Parameter CODE_WIDTH, default 10: width of the output PCM code, unsigned.
REQ-002 Parameter LOG2_R, default 5: log2 of the decimation ratio R (R = 32); CODE_WIDTH SHALL be ≤ 2*LOG2_R.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 bit_en  in  1  qualifies pdm_in; one bitstream sample per cycle with bit_en=1.
REQ-006 pdm_in  in  1  unipolar 1-bit sigma-delta stream (1 = full scale, 0 = zero).
REQ-007 sample_data  out  CODE_WIDTH  decimated PCM code, unsigned.
REQ-008 sample_valid  out  1  sample_data holds an unconsumed sample.
REQ-009 sample_ready  in  1  consumer accepts; transfer when sample_valid & sample_ready.
REQ-010 overrun  out  1  sticky, set when a decimated sample is dropped.
REQ-011 overrun_clr  in  1  clears overrun.

Function
REQ-012 Filter SHALL be a 2nd-order CIC (sinc^2), internal width W = 2*LOG2_R+1, all integrator/comb arithmetic modulo 2^W.
REQ-013 On each bit_en cycle: int1 <= int1 + pdm_in; int2 <= int2 + int1 (old int1 value); no update when bit_en=0.
REQ-014 Phase counter (LOG2_R bits) SHALL increment per bit_en and wrap R-1 -> 0; the bit_en cycle with phase = R-1 is a decimation tick (cycle N).
REQ-015 Cycle N+1: comb stage registers c1 = int2 - d1, d1 <= int2, c2 = c1 - d2, d2 <= c1, using int2 as updated in cycle N.
REQ-016 Scaling: code = c2 >> (2*LOG2_R - CODE_WIDTH), saturated to 2^CODE_WIDTH - 1.
REQ-017 Cycle N+2: code offered; sample_valid high from N+2 if the output register was free or is emptied in that same cycle.
REQ-018 First 2 decimation results after reset SHALL be discarded (priming); third and later are emitted.
REQ-019 Output register single-entry; sample_data stable while sample_valid & !sample_ready.
REQ-020 New result with register full and sample_ready=0: new result dropped, held sample kept, overrun set.
REQ-021 New result in a cycle with a transfer: transfer completes, new result loaded, sample_valid stays 1, no overrun.
REQ-022 overrun_clr and overrun-set in the same cycle: set wins.
REQ-023 bit_en SHALL never be stalled; filter runs regardless of output backpressure.
REQ-024 Steady state: constant 1 -> 2^CODE_WIDTH - 1 (saturated from R^2); constant 0 -> 0; alternating 1/0 -> R^2/2 scaled (512 at defaults).

Reset
REQ-025 rst SHALL clear int1, int2, d1, d2, c1, c2, phase counter, priming counter, sample_data (0), sample_valid (0), overrun (0).
REQ-026 bit_en, pdm_in, sample_ready, overrun_clr SHALL be ignored while rst=1; rst mid-window discards the partial window and restarts priming.

Structure
REQ-027 Shared package sigma_delta_pkg SHALL hold CIC order (2) and the internal-width function W(LOG2_R), also used by sigma_delta_dac tests.
REQ-028 Integrators, phase counter and comb SHALL live in sub-module cic2_core (outputs raw c2 + result strobe); top holds priming, scaling, saturation, handshake, overrun.

Verification
REQ-029 Reset, then 200 bit_en cycles of pdm_in=1, sample_ready=1 -> exactly 4 samples (ticks 3..6 of 6), each 1023, overrun=0.
REQ-030 Alternating 1/0 at bit_en every cycle, ready=1 -> every emitted sample = 512; first valid 2 cycles after the 3rd tick.
REQ-031 pdm_in=1 with bit_en every 3rd cycle -> sample spacing 96 cycles, values 1023; phase unaffected by idle cycles.
REQ-032 sample_ready=0 across 2 ticks after first valid -> first sample held unchanged, overrun=1 after second tick; overrun_clr pulse -> overrun=0.
REQ-033 sample_ready asserted exactly in the cycle a new result arrives -> old sample transferred, new one valid next cycle, overrun=0.
REQ-034 rst asserted mid-window (phase=17) -> all outputs 0 next cycle; next emitted sample only after 3 full new windows.
